// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit: operation encoding, default width
// and the single-bit operation used by every bit slice of the core.
package logic_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_TAG_W = 4;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    function automatic logic op_bit(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Ready/valid request and response bundle for the pipelined logic unit.
interface logic_unit_pipe_if
    import logic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = DEFAULT_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    op_e              in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_sign;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_sign, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_sign, out_tag
    );
endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise logic core with zero/sign flags; shared with the ALU's
// single-cycle path, so it holds no state.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign result[gi] = op_bit(op, a[gi], b[gi]);
        end
    endgenerate

    assign zero = ~|result;
    assign sign = result[WIDTH-1];
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage ready/valid pipeline around logic_op_core: operand register then
// result register, full throughput, bubble collapse under downstream stall.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus
);
    logic             s1_valid_reg;
    op_e              s1_op_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic             s2_zero_reg;
    logic             s2_sign_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_sign;
    logic             s1_en;
    logic             s2_en;

    // out_ready reaches in_ready combinationally so a full pipe frees up in the same cycle
    assign s2_en       = ~s2_valid_reg | bus.out_ready;
    assign s1_en       = ~s1_valid_reg | s2_en;
    assign bus.in_ready = s1_en;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op_reg),
        .a      (s1_a_reg),
        .b      (s1_b_reg),
        .result (core_result),
        .zero   (core_zero),
        .sign   (core_sign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_op_reg     <= OP_AND;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_tag_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_zero_reg   <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_tag_reg    <= '0;
        end else begin
            // Data registers load only behind a valid so idle-bus X never reaches them
            if (s1_en) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op_reg  <= bus.in_op;
                    s1_a_reg   <= bus.in_a;
                    s1_b_reg   <= bus.in_b;
                    s1_tag_reg <= bus.in_tag;
                end
            end
            if (s2_en) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_result_reg <= core_result;
                    s2_zero_reg   <= core_zero;
                    s2_sign_reg   <= core_sign;
                    s2_tag_reg    <= s1_tag_reg;
                end
            end
        end
    end

    assign bus.out_valid  = s2_valid_reg;
    assign bus.out_result = s2_result_reg;
    assign bus.out_zero   = s2_zero_reg;
    assign bus.out_sign   = s2_sign_reg;
    assign bus.out_tag    = s2_tag_reg;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 32-bit/4-bit-tag instance and an
// 8-bit/1-bit-tag instance, with an in-order queue of hand-computed results.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        s;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   rcv32      = 0;
    int   rcv8       = 0;
    int   base;
    exp_t exp32[$];
    exp_t exp8[$];

    logic [31:0] sw_res  [8] = '{32'hF000_000F, 32'hFFF0_0FFF, 32'h0FF0_0FF0, 32'h000F_F000,
                                 32'h0FFF_FFF0, 32'hF00F_F00F, 32'h00F0_00F0, 32'hF0F0_00FF};
    logic        sw_sign [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic_unit_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
    logic_unit_pipe_if #(.WIDTH(8),  .TAG_W(1)) bus8 ();

    logic_unit_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    logic_unit_pipe #(.WIDTH(8), .TAG_W(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic set32(input op_e op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus32.in_valid = 1'b1;
        bus32.in_op    = op;
        bus32.in_a     = a;
        bus32.in_b     = b;
        bus32.in_tag   = tag;
    endtask

    task automatic drive32(input op_e op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           input logic [31:0] res, input logic z, input logic s);
        exp_t e;
        set32(op, a, b, tag);
        e.res = res; e.z = z; e.s = s; e.tag = tag;
        exp32.push_back(e);
    endtask

    task automatic drive8(input op_e op, input logic [7:0] a, input logic [7:0] b, input logic tag,
                          input logic [7:0] res, input logic z, input logic s);
        exp_t e;
        bus8.in_valid = 1'b1;
        bus8.in_op    = op;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_tag   = tag;
        e.res = 32'(res); e.z = z; e.s = s; e.tag = 4'(tag);
        exp8.push_back(e);
    endtask

    // One clock: outputs that transfer at the coming edge are checked in order on the negedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus32.out_valid && bus32.out_ready) begin
            rcv32++;
            chk("pending32", 64'(exp32.size() != 0), 64'(1));
            if (exp32.size() != 0) begin
                e = exp32.pop_front();
                $display("out32 tag=%0h result=%08h zero=%0b sign=%0b", bus32.out_tag, bus32.out_result,
                         bus32.out_zero, bus32.out_sign);
                chk("res32",  64'(bus32.out_result), 64'(e.res));
                chk("zero32", 64'(bus32.out_zero),   64'(e.z));
                chk("sign32", 64'(bus32.out_sign),   64'(e.s));
                chk("tag32",  64'(bus32.out_tag),    64'(e.tag));
            end
        end
        if (bus8.out_valid && bus8.out_ready) begin
            rcv8++;
            chk("pending8", 64'(exp8.size() != 0), 64'(1));
            if (exp8.size() != 0) begin
                e = exp8.pop_front();
                $display("out8 tag=%0h result=%02h zero=%0b sign=%0b", bus8.out_tag, bus8.out_result,
                         bus8.out_zero, bus8.out_sign);
                chk("res8",  64'(bus8.out_result), 64'(e.res));
                chk("zero8", 64'(bus8.out_zero),   64'(e.z));
                chk("sign8", 64'(bus8.out_sign),   64'(e.s));
                chk("tag8",  64'(bus8.out_tag),    64'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus32.in_valid = 1'b0; bus32.in_op = OP_AND; bus32.in_a = '0; bus32.in_b = '0; bus32.in_tag = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_op = OP_AND; bus8.in_a = '0; bus8.in_b = '0; bus8.in_tag = '0;
        bus8.out_ready = 1'b1;

        // Reset, then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus32.out_valid),  64'(0));
        chk("rst_in_ready",  64'(bus32.in_ready),   64'(1));
        chk("rst_result",    64'(bus32.out_result), 64'(0));
        chk("rst_zero",      64'(bus32.out_zero),   64'(0));
        chk("rst_sign",      64'(bus32.out_sign),   64'(0));
        chk("rst_tag",       64'(bus32.out_tag),    64'(0));
        chk("rst_out_valid8", 64'(bus8.out_valid),  64'(0));
        rst = 1'b0;
        tick();
        chk("idle_out_valid", 64'(bus32.out_valid), 64'(0));

        // Op sweep: result registered one edge after capture, visible for the next edge
        for (int i = 0; i < 8; i++) begin
            drive32(op_e'(i), 32'hF0F0_00FF, 32'hFF00_0F0F, 4'(i), sw_res[i], 1'b0, sw_sign[i]);
            chk("sweep_in_ready", 64'(bus32.in_ready), 64'(1));
            tick();
            chk("sweep_latency", 64'(bus32.out_valid), 64'(i >= 1));
        end
        bus32.in_valid = 1'b0;
        repeat (3) tick();
        chk("sweep_count", 64'(rcv32), 64'(8));

        // Flags
        drive32(OP_AND, 32'h0000_FFFF, 32'hFFFF_0000, 4'h8, 32'h0000_0000, 1'b1, 1'b0);
        tick();
        drive32(OP_OR,  32'h8000_0000, 32'h0000_0000, 4'h9, 32'h8000_0000, 1'b0, 1'b1);
        tick();
        bus32.in_valid = 1'b0;
        repeat (3) tick();
        chk("flags_drained", 64'(exp32.size()), 64'(0));

        // Backpressure: out_ready drops in the second cycle, pipe fills with two
        base = rcv32;
        drive32(OP_OR, 32'd1, 32'h100, 4'd1, 32'h101, 1'b0, 1'b0);
        tick();
        bus32.out_ready = 1'b0;
        drive32(OP_OR, 32'd2, 32'h100, 4'd2, 32'h102, 1'b0, 1'b0);
        chk("bp_ready_before_full", 64'(bus32.in_ready), 64'(1));
        tick();
        chk("bp_ready_full", 64'(bus32.in_ready),  64'(0));
        chk("bp_valid_full", 64'(bus32.out_valid), 64'(1));
        drive32(OP_OR, 32'd3, 32'h100, 4'd3, 32'h103, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready_stall",  64'(bus32.in_ready),   64'(0));
            chk("bp_valid_stall",  64'(bus32.out_valid),  64'(1));
            chk("bp_result_stall", 64'(bus32.out_result), 64'(32'h101));
            chk("bp_tag_stall",    64'(bus32.out_tag),    64'(1));
        end
        bus32.out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 64'(bus32.in_ready), 64'(1));
        tick();
        drive32(OP_OR, 32'd4, 32'h100, 4'd4, 32'h104, 1'b0, 1'b0);
        tick();
        drive32(OP_OR, 32'd5, 32'h100, 4'd5, 32'h105, 1'b0, 1'b0);
        tick();
        bus32.in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", 64'(rcv32 - base), 64'(5));

        // Reset with two transactions in flight: neither may ever emerge
        set32(OP_XOR, 32'hFFFF_FFFF, 32'h0, 4'hA);
        tick();
        bus32.out_ready = 1'b0;
        set32(OP_XOR, 32'h1234_5678, 32'h0, 4'hB);
        tick();
        chk("mid_full_valid", 64'(bus32.out_valid), 64'(1));
        chk("mid_full_ready", 64'(bus32.in_ready),  64'(0));
        rst = 1'b1;
        bus32.in_valid = 1'b0;
        tick();
        chk("mid_rst_valid",  64'(bus32.out_valid),  64'(0));
        chk("mid_rst_ready",  64'(bus32.in_ready),   64'(1));
        chk("mid_rst_result", 64'(bus32.out_result), 64'(0));
        chk("mid_rst_tag",    64'(bus32.out_tag),    64'(0));
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        base = rcv32;
        repeat (3) tick();
        chk("mid_no_ghost", 64'(rcv32 - base), 64'(0));
        drive32(OP_NAND, 32'hFFFF_FFFF, 32'h0000_FFFF, 4'hC, 32'hFFFF_0000, 1'b0, 1'b1);
        tick();
        bus32.in_valid = 1'b0;
        chk("mid_recover_lat0", 64'(bus32.out_valid), 64'(0));
        tick();
        chk("mid_recover_lat1", 64'(bus32.out_valid), 64'(1));
        repeat (2) tick();
        chk("mid_recover_count", 64'(rcv32 - base), 64'(1));

        // Narrow build: WIDTH=8, TAG_W=1
        drive8(OP_XOR, 8'hA5, 8'hFF, 1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        drive8(OP_AND, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        bus8.in_valid = 1'b0;
        repeat (3) tick();
        chk("w8_count", 64'(rcv8), 64'(2));

        // Sixteen back-to-back ops at one per cycle: F0 ^ i for i < 16 is F0 | i
        base = rcv8;
        for (int i = 0; i < 16; i++) begin
            drive8(OP_XOR, 8'(i), 8'hF0, 1'(i), 8'hF0 | 8'(i), 1'b0, 1'b1);
            chk("w8_tp_ready", 64'(bus8.in_ready), 64'(1));
            tick();
            if (i >= 1) chk("w8_tp_valid", 64'(bus8.out_valid), 64'(1));
        end
        bus8.in_valid = 1'b0;
        repeat (3) tick();
        chk("w8_tp_count", 64'(rcv8 - base), 64'(16));
        chk("w8_tp_drained", 64'(exp8.size()), 64'(0));
        chk("final_drained32", 64'(exp32.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the 32-bit RISC ALU; successor to the fixed 32-bit AND array.
- Supports eight bitwise operations on WIDTH-bit operands, selected per transaction.
- Two-stage valid/ready pipeline (operand register, result register) with full throughput and backpressure.
- Zero and sign flags are produced alongside the result for the ALU flag mux.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
TAG_W, 4, width of the sideband tag carried with each transaction (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream has a transaction
in_ready  output  1  unit accepts a transaction this cycle
in_op  input  3  operation select (encoding in package)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  operation result
out_zero  output  1  1 when out_result == 0
out_sign  output  1  out_result[WIDTH-1]
out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset: rst sampled on clk edge only. s1_valid=0, s2_valid=0, out_result=0, out_zero=0, out_sign=0, out_tag=0. in_ready is combinational and is 1 during and after reset (empty pipe). Reset mid-operation discards all in-flight transactions; no result emitted.
- Op encoding (3 bits): 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (A & ~B), 7 PASSA (A).
- Stage 1 (operand reg): captures op/a/b/tag when in_valid & in_ready.
- Stage 2 (result reg): computes the op from stage-1 operands; registers result, zero, sign and tag.
- Handshake (ready/valid, AXI-style): transfer occurs when valid & ready are both high on a clk edge. Valid, once asserted, holds with stable data until accepted; out_* stable while out_valid & ~out_ready.
- Advance rules: s2_en = ~s2_valid | out_ready; s1_en = ~s1_valid | s2_en; in_ready = s1_en.
- On s2_en: s2_valid <= s1_valid; data loaded only when s1_valid. On s1_en: s1_valid <= in_valid.
- Latency: accept at edge N -> out_valid at edge N+2 with no backpressure. Throughput 1 result/cycle with out_ready held high.
- Backpressure: with out_ready low, the pipe fills with two transactions, then in_ready drops. in_ready rises in the same cycle out_ready rises (combinational path out_ready -> in_ready, documented).
- Bubbles: an empty stage is filled regardless of downstream stall (bubble collapse); no transaction is lost or duplicated.
- Simultaneous accept and emit: permitted in the same cycle; order preserved FIFO.
- in_op, in_a, in_b, in_tag ignored when in_valid=0; X on them must not propagate to valid flags.
- Flags: out_zero = ~|result; out_sign = result MSB; both computed in stage 2, aligned with out_result.

Decomposition:
- Package logic_pkg: 3-bit op typedef/constants OP_AND..OP_PASSA, default WIDTH.
- Sub-module logic_op_core (combinational, WIDTH-parametrised): op, a, b -> result, zero, sign; generate-loop per bit, reusable by the ALU's single-cycle path.
- logic_unit_pipe holds the two pipeline stages and handshake logic only.

Test Plan:
- Reset then idle: rst=1 two cycles -> out_valid=0, in_ready=1, out_result=0, out_zero=0.
- Op sweep, WIDTH=32, A=F0F0_00FF, B=FF00_0F0F, out_ready=1 -> AND F000_000F, OR FFF0_0FFF, XOR 0FF0_0FF0, NOR 000F_F000, NAND 0FFF_FFF0, XNOR F00F_F00F, ANDN 00F0_00F0, PASSA F0F0_00FF; each at accept+2, tags 0..7 returned in order.
- Flags: AND A=0000_FFFF, B=FFFF_0000 -> result 0, zero=1, sign=0; OR A=8000_0000, B=0 -> zero=0, sign=1.
- Backpressure: stream 5 ops, out_ready=0 from cycle 2 -> in_ready drops after 2 held; release out_ready -> all 5 results in order, outputs stable while stalled, none lost.
- Reset mid-stream: 2 transactions in flight, rst=1 one cycle -> out_valid=0 next cycle, those results never appear; next accepted op emits normally.
- Parametrised build WIDTH=8, TAG_W=1: XOR A=0xA5, B=0xFF -> 0x5A, zero=0, sign=0; full-throughput run of 16 back-to-back ops at 1/cycle.
